// File: rtl/decod_pkg.sv
// Shared types and constants for the registered one-hot decoder with sweep mode.
package decod_pkg;

  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned OUT_W_DEF = 2 ** SEL_W_DEF;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  function automatic logic [OUT_W_DEF-1:0] onehot(input logic [SEL_W_DEF-1:0] sel);
    logic [OUT_W_DEF-1:0] code;
    code      = '0;
    code[sel] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/decod_sweep_pipe_if.sv
// Request/beat channel bundle for decod_sweep_pipe; slave is the decoder, master the requester.
interface decod_sweep_pipe_if #(
  parameter int unsigned SEL_W = decod_pkg::SEL_W_DEF
);
  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_en;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [SEL_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_sel, in_en, in_mode, out_ready,
    input  in_ready, out_valid, out_onehot, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_sel, in_en, in_mode, out_ready,
    output in_ready, out_valid, out_onehot, out_idx, out_last, busy
  );

endinterface

// File: rtl/decod_onehot.sv
// Combinational SEL_W-to-2**SEL_W decoder with enable; disabled gives an all-zero code.
module decod_onehot
  import decod_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/decod_sweep_pipe.sv
// Registered one-hot decoder: single decode or sweep 0..sel, valid/ready on both sides.
// Build option DECOD_SWEEP_PIPE_ONECOLD_EN inverts out_onehot at the port (active-low strobes).
module decod_sweep_pipe
  import decod_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input logic              clk,
  input logic              rst,
  decod_sweep_pipe_if.slave bus
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_valid;
  logic             r_last;
  logic [OUT_W-1:0] r_onehot;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_end;

  logic             w_valid_nxt;
  logic             w_last_nxt;
  logic [OUT_W-1:0] w_onehot_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [SEL_W-1:0] w_end_nxt;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_hs;
  logic [OUT_W-1:0] w_dec;
  logic [SEL_W-1:0] w_idx_inc;
  logic             w_sweep_end;

  decod_onehot #(
    .SEL_W(SEL_W)
  ) u_dec (
    .i_sel   (bus.in_sel),
    .i_en    (bus.in_en),
    .o_onehot(w_dec)
  );

  assign w_acc       = bus.in_valid && w_in_ready;
  assign w_hs        = r_valid && bus.out_ready;
  assign w_idx_inc   = r_idx + {{(SEL_W-1){1'b0}}, 1'b1};
  assign w_sweep_end = (w_idx_inc == r_end);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The beat carrying last returns to IDLE as it is loaded, so the sweep's final
  // handshake can already accept the next request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc && bus.in_en && bus.in_mode && (bus.in_sel != '0)) w_state_nxt = SWEEP;
      SWEEP:   if (w_hs && w_sweep_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready     = (r_state == IDLE) && (!r_valid || bus.out_ready) && !rst;
    bus.in_ready   = w_in_ready;
    bus.busy       = (r_state != IDLE) || r_valid;
    bus.out_valid  = r_valid;
    bus.out_idx    = r_idx;
    bus.out_last   = r_last;
`ifdef DECOD_SWEEP_PIPE_ONECOLD_EN
    bus.out_onehot = ~r_onehot;
`else
    bus.out_onehot = r_onehot;
`endif
  end

  always_comb begin
    w_valid_nxt  = r_valid;
    w_onehot_nxt = r_onehot;
    w_idx_nxt    = r_idx;
    w_last_nxt   = r_last;
    w_end_nxt    = r_end;
    if (w_acc) begin
      w_valid_nxt = 1'b1;
      if (bus.in_en && bus.in_mode) begin
        w_onehot_nxt = {{(OUT_W-1){1'b0}}, 1'b1};
        w_idx_nxt    = '0;
        w_last_nxt   = (bus.in_sel == '0);
        w_end_nxt    = bus.in_sel;
      end else begin
        w_onehot_nxt = w_dec;
        w_idx_nxt    = bus.in_sel;
        w_last_nxt   = 1'b1;
      end
    end else if (w_hs && (r_state == SWEEP)) begin
      w_onehot_nxt = r_onehot << 1;
      w_idx_nxt    = w_idx_inc;
      w_last_nxt   = w_sweep_end;
    end else if (w_hs) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_onehot <= '0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_end    <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_onehot <= w_onehot_nxt;
      r_idx    <= w_idx_nxt;
      r_last   <= w_last_nxt;
      r_end    <= w_end_nxt;
    end
  end

endmodule

// File: tb/tb_decod_sweep_pipe.sv
// Self-checking bench for decod_sweep_pipe: vector table, sweep/backpressure/reset sequences.
module tb_decod_sweep_pipe;

  localparam int unsigned SEL_W = 4;

  typedef struct packed {
    logic [15:0] code;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    int          sel;
    bit          en;
    bit          mode;
    logic [15:0] code;
    int          idx;
    bit          last;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  logic  stall_v = 1'b0;
  beat_t stall_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  decod_sweep_pipe_if #(.SEL_W(SEL_W)) bus ();

  decod_sweep_pipe #(.SEL_W(SEL_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [15:0] port_code(input logic [15:0] c);
`ifdef DECOD_SWEEP_PIPE_ONECOLD_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] code, input int idx, input bit last);
    beat_t b;
    b.code = port_code(code);
    b.idx  = idx[3:0];
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Holds the request until accepted, then drops in_valid one step after the edge.
  task automatic send(input int sel, input bit en, input bit mode);
    int k;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel[3:0];
    bus.in_en    = en;
    bus.in_mode  = mode;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready 0, expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard plus stall-stability monitor.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {bus.out_onehot, bus.out_idx, bus.out_last};
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        chk("stall_valid_held", {31'b0, bus.out_valid}, 1);
        if (bus.out_valid) chk("stall_beat_stable", cur, stall_b);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got code 0x%0h idx %0d, expected no beat",
                   bus.out_onehot, bus.out_idx);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        stall_v = 1'b0;
      end else if (bus.out_valid) begin
        stall_v = 1'b1;
        stall_b = cur;
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  initial begin
    vec_t tbl[8];
    int   c0;
    bit   found;

    tbl[0] = '{sel: 5,  en: 1, mode: 0, code: 16'h0020, idx: 5,  last: 1};
    tbl[1] = '{sel: 9,  en: 1, mode: 0, code: 16'h0200, idx: 9,  last: 1};
    tbl[2] = '{sel: 3,  en: 0, mode: 1, code: 16'h0000, idx: 3,  last: 1};
    tbl[3] = '{sel: 0,  en: 1, mode: 0, code: 16'h0001, idx: 0,  last: 1};
    tbl[4] = '{sel: 15, en: 1, mode: 0, code: 16'h8000, idx: 15, last: 1};
    tbl[5] = '{sel: 7,  en: 0, mode: 0, code: 16'h0000, idx: 7,  last: 1};
    tbl[6] = '{sel: 0,  en: 1, mode: 1, code: 16'h0001, idx: 0,  last: 1};
    tbl[7] = '{sel: 2,  en: 1, mode: 0, code: 16'h0004, idx: 2,  last: 1};

    bus.in_valid  = 1'b1;
    bus.in_sel    = '0;
    bus.in_en     = 1'b0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Reset holds everything quiet even with a pending request.
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_onehot", {16'b0, bus.out_onehot}, {16'b0, port_code(16'h0000)});
      chk("rst_busy", {31'b0, bus.busy}, 0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, bus.in_ready}, 1);
    @(posedge clk);
    #1;

    // Back-to-back singles with no bubble.
    send(5, 1'b1, 1'b0);
    push(16'h0020, 5, 1'b1);
    c0 = cyc;
    chk("b2b_first_valid", {31'b0, bus.out_valid}, 1);
    chk("b2b_first_code", {16'b0, bus.out_onehot}, {16'b0, port_code(16'h0020)});
    send(9, 1'b1, 1'b0);
    push(16'h0200, 9, 1'b1);
    chk("b2b_gap_cycles", cyc - c0, 1);
    chk("b2b_second_code", {16'b0, bus.out_onehot}, {16'b0, port_code(16'h0200)});
    drain();

    // Vector table, issued back to back.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].sel, tbl[i].en, tbl[i].mode);
      push(tbl[i].code, tbl[i].idx, tbl[i].last);
    end
    drain();

    // Disabled sweep request must not enter SWEEP.
    send(3, 1'b0, 1'b1);
    push(16'h0000, 3, 1'b1);
    chk("dis_busy_during_beat", {31'b0, bus.busy}, 1);
    @(posedge clk);
    #1;
    chk("dis_busy_after", {31'b0, bus.busy}, 0);
    chk("dis_valid_after", {31'b0, bus.out_valid}, 0);
    drain();

    // Full sweep at one beat per cycle.
    send(15, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) push(16'h0001 << i, i, i == 15);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.out_valid && !bus.out_last) chk("sweep_in_ready", {31'b0, bus.in_ready}, 0);
    end
    @(posedge clk);
    #1;
    chk("sweep_rate_queue", exp_q.size(), 0);
    chk("sweep_done_valid", {31'b0, bus.out_valid}, 0);
    chk("sweep_done_busy", {31'b0, bus.busy}, 0);
    drain();

    // Backpressure: out_ready pattern 1,0,0 repeating.
    send(3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(16'h0001 << i, i, i == 3);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      bus.out_ready = (k % 3 == 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    chk("bp_all_beats", exp_q.size(), 0);
    drain();

    // Reset while beat 2 of a sel=7 sweep is pending.
    send(7, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) push(16'h0001 << i, i, i == 7);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (bus.out_valid && bus.out_idx == 4'd2) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("rst_mid_found_beat2", {31'b0, found}, 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_mid_busy", {31'b0, bus.busy}, 0);
    repeat (5) begin
      @(negedge clk);
      chk("rst_mid_no_beat", {31'b0, bus.out_valid}, 0);
    end
    @(posedge clk);
    #1;
    send(2, 1'b1, 1'b0);
    push(16'h0004, 2, 1'b1);
    chk("post_rst_single_code", {16'b0, bus.out_onehot}, {16'b0, port_code(16'h0004)});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decod_sweep_pipe.md
Name: decod_sweep_pipe

Overview:
- Parametrised, registered successor to the team's combinational 4-to-16 enable decoder.
- Accepts a select word through a valid/ready handshake and emits one-hot codes on a registered valid/ready output.
- Single mode: emits one code.
- Sweep mode: walks indices 0..sel, one beat per accepted output, with a last flag.
- Sits between command decode and per-channel strobe fan-out.

Parameters:
SEL_W, 4, select width; derived localparam OUT_W = 2**SEL_W (16 by default).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_sel  in  SEL_W  target index (single) or final index (sweep)
in_en  in  1  decode enable; 0 gives an all-zero code
in_mode  in  1  0 = single, 1 = sweep
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_onehot  out  OUT_W  decoded code
out_idx  out  SEL_W  index of current beat
out_last  out  1  final beat of request
busy  out  1  state != IDLE or out_valid

Behaviour:
- Reset: synchronous, active-high; clock and reset are one clk / rst pair.
  - On rst: state=IDLE, out_valid=0, out_onehot=0, out_idx=0, out_last=0, busy=0.
  - in_ready=0 while rst is high.
  - rst mid-sweep aborts the sweep: no further beats, and the pending beat is dropped.
- States: IDLE, SWEEP.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !rst. This gives zero-bubble back-to-back single requests.
- Accept in IDLE, beat registered next cycle (latency 1):
  - in_en=0 (any mode): out_onehot=0, out_idx=in_sel, out_last=1; stay IDLE.
  - in_en=1, mode=0: out_onehot=1<<in_sel, out_idx=in_sel, out_last=1; stay IDLE.
  - in_en=1, mode=1: latch end=in_sel; emit idx 0 with out_onehot=1; out_last=(in_sel==0). Go to SWEEP unless in_sel==0.
- SWEEP:
  - On out_valid & out_ready: idx+1, onehot shifts left by 1, out_last=(idx+1==end).
  - The beat with out_last=1 returns state to IDLE in the same cycle it is registered.
  - Throughput: 1 beat/cycle when out_ready is held high.
  - in_ready stays 0 throughout SWEEP.
- Output stability: out_onehot, out_idx and out_last hold stable while out_valid & !out_ready. A dropped out_valid without handshake is forbidden.
- out_valid clears on handshake unless a new beat is loaded in the same cycle.
- Width rule: idx counter is SEL_W bits. The sweep end is <= OUT_W-1, so the counter never wraps. in_sel = all-ones produces OUT_W beats.
- busy is combinational from registered state.

Optional Feature:
Macro DECOD_SWEEP_PIPE_ONECOLD_EN.
- Defined: out_onehot is driven as the bitwise inverse (one-cold, active-low strobes). A disabled beat is then all-ones. The internal register still holds the one-hot code; inversion happens at the port.
- Undefined: active-high one-hot as above.
- Handshake, idx, last and timing are identical in both builds.

Decomposition:
- Package decod_pkg:
  - state enum {IDLE, SWEEP}
  - default SEL_W constant
  - function onehot(sel) returning an OUT_W vector
- One sub-module, decod_onehot: purely combinational, parametrised SEL_W decoder with enable. It computes the load value for single mode; the top owns the FSM, counter and output register.

Test Plan:
1. Reset/idle: assert rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_onehot=0, busy=0; first cycle after release -> in_ready=1.
2. Single decode: SEL_W=4, sel=5, en=1, mode=0, out_ready=1 -> next cycle out_onehot=16'h0020, idx=5, last=1. Back-to-back sel=5 then sel=9 -> consecutive beats 0x0020, 0x0200, no bubble.
3. Disabled: en=0, sel=3, mode=1 -> single beat out_onehot=0, last=1; no SWEEP entry (busy low after handshake).
4. Full sweep: sel=15, mode=1, out_ready=1 -> 16 consecutive beats 0x0001..0x8000, idx 0..15, last only on idx 15; in_ready=0 throughout; sel=0 sweep -> one beat 0x0001, last=1.
5. Backpressure: sweep sel=3 with out_ready toggling 1,0,0,1,... -> beat contents held stable while stalled; beats are exactly 0x1,0x2,0x4,0x8 in order with no duplicates or drops.
6. Reset mid-sweep, with ONECOLD build: rst at beat 2 of sel=7 sweep -> out_valid=0 next cycle, no further beats. Rerun single sel=2 with DECOD_SWEEP_PIPE_ONECOLD_EN -> out_onehot=16'hFFFB.
